// File: rtl/yarp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : yarp_pkg                                                        |
// | Purpose  : Shared types and constants for the YARP line-fill unit.        |
// |            - lfu_state_e   : line-fill FSM state encoding                  |
// |            - LFU_LINE_WORDS: default number of 32-bit words per line       |
// |            - lfu_idx_width : width of a word index within a line           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package yarp_pkg;

  localparam int LFU_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } lfu_state_e;

  // Word-index width inside a line; never below 1 so index vectors stay legal.
  function automatic int lfu_idx_width(input int line_words);
    return (line_words > 2) ? $clog2(line_words) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/yarp_line_fill_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : yarp_line_fill_if                                               |
// | Purpose  : Main-memory read bus between the line-fill unit and memory.    |
// |            Signal suffixes are from the line-fill unit's point of view.   |
// | Ports    : mem_req_o    read request                                       |
// |            mem_addr_o   word-aligned read address                          |
// |            mem_gnt_i    request accepted this cycle                        |
// |            mem_rvalid_i read data valid (in order)                         |
// |            mem_rdata_i  read data                                          |
// | Modports : master = line-fill unit, slave = memory                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface yarp_line_fill_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/yarp_lfu_line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : yarp_lfu_line_buf                                               |
// | Purpose  : LINE_WORDS x 32 line buffer. Responses arrive in wrapped order, |
// |            so the physical word written is crit_idx + rsp_cnt (mod lines). |
// | Ports    : clk, reset_n   clock, async active-low reset                    |
// |            clear_i        zero every word (start of a new fill)            |
// |            wr_en_i        write wr_data_i at the rotated index             |
// |            crit_idx_i     critical word index of the current fill          |
// |            rsp_cnt_i      number of responses already written              |
// |            wr_data_i      response data                                    |
// |            line_o         flat line, word 0 at the LSBs                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module yarp_lfu_line_buf
  import yarp_pkg::*;
#(
  parameter int LINE_WORDS = LFU_LINE_WORDS
) (
  input  wire logic                                        clk,
  input  wire logic                                        reset_n,
  input  wire logic                                        clear_i,
  input  wire logic                                        wr_en_i,
  input  wire logic [lfu_idx_width(LINE_WORDS)-1:0]        crit_idx_i,
  input  wire logic [lfu_idx_width(LINE_WORDS)-1:0]        rsp_cnt_i,
  input  wire logic [31:0]                                 wr_data_i,
  output logic      [32*LINE_WORDS-1:0]                    line_o
);

  localparam int IDXW = lfu_idx_width(LINE_WORDS);

  // Index arithmetic is IDXW bits wide, so the addition wraps inside the line.
  logic [IDXW-1:0] wr_idx;
  assign wr_idx = crit_idx_i + rsp_cnt_i;

  generate
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_word
      logic [31:0] word_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_q <= '0;
        end else if (clear_i) begin
          word_q <= '0;
        end else if (wr_en_i && (wr_idx == IDXW'(g))) begin
          word_q <= wr_data_i;
        end
      end

      assign line_o[32*g +: 32] = word_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/yarp_line_fill.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : yarp_line_fill                                                  |
// | Purpose  : Cache line refill engine. Takes one line miss, issues          |
// |            LINE_WORDS single-word reads critical-word-first (wrapping),   |
// |            returns the critical word early and then the complete line.    |
// | Ports    : clk, reset_n    clock, async active-low reset                   |
// |            miss_req_i/miss_addr_i/miss_ack_o   miss request handshake      |
// |            busy_o          fill in progress                                |
// |            crit_valid_o/crit_data_o            early critical word         |
// |            fill_done_o/fill_err_o              completion pulse / abort    |
// |            fill_addr_o/fill_line_o             completed line and address  |
// |            mem             memory read bus (yarp_line_fill_if.master)      |
// | Config   : `define YARP_LFU_TIMEOUT_EN enables the no-progress timeout    |
// |            (TIMEOUT_CYCLES); otherwise fill_err_o is tied low.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module yarp_line_fill
  import yarp_pkg::*;
#(
  parameter int LINE_WORDS     = LFU_LINE_WORDS
`ifdef YARP_LFU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic                       miss_req_i,
  input  wire logic [31:0]                miss_addr_i,
  output logic                            miss_ack_o,
  output logic                            busy_o,
  output logic                            crit_valid_o,
  output logic      [31:0]                crit_data_o,
  output logic                            fill_done_o,
  output logic                            fill_err_o,
  output logic      [31:0]                fill_addr_o,
  output logic      [32*LINE_WORDS-1:0]   fill_line_o,
  yarp_line_fill_if.master                mem
);

  localparam int IDXW = lfu_idx_width(LINE_WORDS);
  localparam int CNTW = IDXW + 1;          // counts 0..LINE_WORDS inclusive
  localparam int TAGW = 32 - 2 - IDXW;

  lfu_state_e                 state_q, state_d;
  logic [TAGW-1:0]            tag_q;
  logic [IDXW-1:0]            crit_idx_q;
  logic [CNTW-1:0]            issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]            rsp_cnt_q, rsp_cnt_d;
  logic                       crit_valid_q;
  logic [31:0]                crit_data_q;
  logic [31:0]                fill_addr_q;
  logic [32*LINE_WORDS-1:0]   fill_line_q;
  logic [32*LINE_WORDS-1:0]   buf_line;

  logic                       ack_w;
  logic                       req_w;
  logic                       gnt_w;
  logic                       rsp_ok_w;
  logic                       buf_clear_w;
  logic                       buf_wr_w;
  logic [IDXW-1:0]            issue_idx_w;
  logic [31:0]                line_addr_w;
  logic                       unused_byte_off;

  // The byte offset within the missing word does not affect the fill.
  assign unused_byte_off = ^miss_addr_i[1:0];

  assign ack_w       = miss_req_i && (state_q == IDLE);
  assign req_w       = (state_q == FILL) && (issue_cnt_q < CNTW'(LINE_WORDS));
  assign gnt_w       = req_w && mem.mem_gnt_i;
  // A response is only legal for a read that has already been granted.
  assign rsp_ok_w    = mem.mem_rvalid_i && (state_q == FILL) && (rsp_cnt_q < issue_cnt_q);
  assign issue_idx_w = crit_idx_q + issue_cnt_q[IDXW-1:0];
  assign line_addr_w = {tag_q, {(IDXW+2){1'b0}}};

  assign miss_ack_o     = ack_w;
  assign busy_o         = (state_q != IDLE);
  assign mem.mem_req_o  = req_w;
  // Only the index field is rotated, so the address never leaves the line.
  assign mem.mem_addr_o = {tag_q, issue_idx_w, 2'b00};
  assign crit_valid_o   = crit_valid_q;
  assign crit_data_o    = crit_data_q;
  assign fill_done_o    = (state_q == DONE);
  // During DONE the buffer already holds the full line; afterwards the held
  // copy keeps the result stable while the buffer is reused by the next fill.
  assign fill_line_o    = (state_q == DONE) ? buf_line    : fill_line_q;
  assign fill_addr_o    = (state_q == DONE) ? line_addr_w : fill_addr_q;

`ifdef YARP_LFU_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] prog_cnt_q;
  logic           err_q;
  logic           timeout_w;

  // Fires on the cycle the counter would reach TIMEOUT_CYCLES.
  assign timeout_w = (state_q == FILL) && !gnt_w && !mem.mem_rvalid_i &&
                     (prog_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (ack_w || gnt_w || mem.mem_rvalid_i || (state_q != FILL)) begin
        prog_cnt_q <= '0;
      end else begin
        prog_cnt_q <= prog_cnt_q + TOW'(1);
      end
      if (ack_w) begin
        err_q <= 1'b0;
      end else if (timeout_w) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fill_err_o = (state_q == DONE) && err_q;
`else
  assign fill_err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    buf_clear_w = 1'b0;
    buf_wr_w    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ack_w) begin
          state_d     = FILL;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          buf_clear_w = 1'b1;
        end
      end
      FILL: begin
        if (gnt_w) begin
          issue_cnt_d = issue_cnt_q + CNTW'(1);
        end
        if (rsp_ok_w) begin
          buf_wr_w  = 1'b1;
          rsp_cnt_d = rsp_cnt_q + CNTW'(1);
          if (rsp_cnt_q == CNTW'(LINE_WORDS - 1)) begin
            state_d = DONE;
          end
        end
`ifdef YARP_LFU_TIMEOUT_EN
        if (timeout_w) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      crit_idx_q   <= '0;
      issue_cnt_q  <= '0;
      rsp_cnt_q    <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_addr_q  <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      if (ack_w) begin
        tag_q      <= miss_addr_i[31:2+IDXW];
        crit_idx_q <= miss_addr_i[2+IDXW-1:2];
      end
      crit_valid_q <= rsp_ok_w && (rsp_cnt_q == '0);
      if (rsp_ok_w && (rsp_cnt_q == '0)) begin
        crit_data_q <= mem.mem_rdata_i;
      end
      if (state_q == DONE) begin
        fill_line_q <= buf_line;
        fill_addr_q <= line_addr_w;
      end
    end
  end

  yarp_lfu_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (buf_clear_w),
    .wr_en_i    (buf_wr_w),
    .crit_idx_i (crit_idx_q),
    .rsp_cnt_i  (rsp_cnt_q[IDXW-1:0]),
    .wr_data_i  (mem.mem_rdata_i),
    .line_o     (buf_line)
  );

  // Responses without an outstanding read, or outside FILL, are protocol errors.
  a_rvalid_legal : assert property (@(posedge clk) disable iff (!reset_n)
    mem.mem_rvalid_i |-> rsp_ok_w);

endmodule
`default_nettype wire

// File: tb/tb_yarp_line_fill.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_yarp_line_fill                                               |
// | Purpose  : Self-checking bench for yarp_line_fill (LINE_WORDS = 4).       |
// |            A memory model answers reads with data equal to the address;   |
// |            expected addresses, critical words and lines are queued when a |
// |            miss is driven and compared as the DUT produces them.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_yarp_line_fill;

  localparam int LW = 4;

  typedef struct packed {
    logic [31:0]      addr;
    logic [32*LW-1:0] line;
    logic             err;
  } done_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             miss_req_i = 1'b0;
  logic [31:0]      miss_addr_i = '0;
  logic             miss_ack_o, busy_o, crit_valid_o, fill_done_o, fill_err_o;
  logic [31:0]      crit_data_o, fill_addr_o;
  logic [32*LW-1:0] fill_line_o;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int rv_count = 0;
  int stall_n = 0;
  int stall_cnt = 0;
  bit gnt_never = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] crit_q[$];
  done_t       done_q[$];

  yarp_line_fill_if mem_if ();

  yarp_line_fill #(
    .LINE_WORDS     (LW)
`ifdef YARP_LFU_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_req_i   (miss_req_i),
    .miss_addr_i  (miss_addr_i),
    .miss_ack_o   (miss_ack_o),
    .busy_o       (busy_o),
    .crit_valid_o (crit_valid_o),
    .crit_data_o  (crit_data_o),
    .fill_done_o  (fill_done_o),
    .fill_err_o   (fill_err_o),
    .fill_addr_o  (fill_addr_o),
    .fill_line_o  (fill_line_o),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expectations for a normal fill: wrapped addresses, critical word, line.
  task automatic push_miss(input logic [31:0] a);
    logic [31:0] base;
    int          idx;
    done_t       d;
    base = a & ~32'(4*LW-1);
    idx  = int'(a[3:2]);
    for (int i = 0; i < LW; i++) exp_addr_q.push_back(base + 32'(4*((idx + i) % LW)));
    crit_q.push_back(base + 32'(4*idx));
    d.addr = base;
    d.err  = 1'b0;
    for (int i = 0; i < LW; i++) d.line[32*i +: 32] = base + 32'(4*i);
    done_q.push_back(d);
  endtask

  // Memory model: drives gnt/rvalid for the cycle starting at this negedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      rsp_q.delete();
      stall_cnt = 0;
      mem_if.mem_gnt_i    = 1'b0;
      mem_if.mem_rvalid_i = 1'b0;
      mem_if.mem_rdata_i  = '0;
    end else begin
      if (rsp_q.size() > 0) begin
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = rsp_q.pop_front();
        rv_count++;
      end else begin
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
      end
      mem_if.mem_gnt_i = 1'b0;
      if (mem_if.mem_req_o) begin
        if (exp_addr_q.size() == 0) chk("mem_req_unexpected", mem_if.mem_req_o, 1'b0);
        else                        chk("mem_addr", mem_if.mem_addr_o, exp_addr_q[0]);
        if (!gnt_never) begin
          if (stall_cnt < stall_n) begin
            stall_cnt++;
          end else begin
            stall_cnt = 0;
            mem_if.mem_gnt_i = 1'b1;
            rsp_q.push_back(mem_if.mem_addr_o);
            if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
          end
        end
      end
    end
  end

  // Output monitor: critical-word and completion scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (crit_valid_o) begin
        if (crit_q.size() == 0) chk("crit_unexpected", crit_valid_o, 1'b0);
        else                    chk("crit_data", crit_data_o, crit_q.pop_front());
      end
      if (fill_done_o) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", fill_done_o, 1'b0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("fill_addr", fill_addr_o, d.addr);
          chk("fill_line", fill_line_o, d.line);
          chk("fill_err",  fill_err_o,  d.err);
        end
      end
    end
  end

  task automatic start_miss(input logic [31:0] a, input bit keep, output int ack_cyc);
    int n;
    @(negedge clk);
    miss_req_i  = 1'b1;
    miss_addr_i = a;
    #1;
    n = 0;
    while (!miss_ack_o && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("ack_seen", miss_ack_o, 1'b1);
    ack_cyc = cyc;
    @(negedge clk);
    if (!keep) miss_req_i = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!fill_done_o && n < 400);
    chk("done_seen", fill_done_o, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},     busy_o,               1'b0);
    chk({tag, "_ack"},      miss_ack_o,           1'b0);
    chk({tag, "_req"},      mem_if.mem_req_o,     1'b0);
    chk({tag, "_addr"},     mem_if.mem_addr_o,    32'h0);
    chk({tag, "_crit_v"},   crit_valid_o,         1'b0);
    chk({tag, "_crit_d"},   crit_data_o,          32'h0);
    chk({tag, "_done"},     fill_done_o,          1'b0);
    chk({tag, "_err"},      fill_err_o,           1'b0);
    chk({tag, "_fill_a"},   fill_addr_o,          32'h0);
    chk({tag, "_fill_l"},   fill_line_o,          128'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, d, n, bad, rv0;
    logic [127:0] line1;
    line1 = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    #1 reset_n = 1'b1;

    // 1: critical word mid-line
    push_miss(32'h0000_1008);
    start_miss(32'h0000_1008, 1'b0, a);
    wait_done(d);
    chk("t1_latency", d - a, LW + 2);
    chk("t1_line", fill_line_o, line1);
    chk("t1_addr", fill_addr_o, 32'h0000_1000);
    chk("t1_crit", crit_data_o, 32'h0000_1008);

    // 2: aligned miss; previous line must hold during the new fill
    push_miss(32'h0000_2000);
    start_miss(32'h0000_2000, 1'b0, a);
    @(negedge clk); #1;
    chk("t2_line_held", fill_line_o, line1);
    wait_done(d);
    chk("t2_latency", d - a, LW + 2);
    chk("t2_crit", crit_data_o, 32'h0000_2000);

    // 3: last-word critical with grant back-pressure
    stall_n = 3;
    push_miss(32'h0000_300C);
    start_miss(32'h0000_300C, 1'b0, a);
    wait_done(d);
    stall_n = 0;
    chk("t3_line", fill_line_o, {32'h0000_300C, 32'h0000_3008, 32'h0000_3004, 32'h0000_3000});
    chk("t3_crit", crit_data_o, 32'h0000_300C);

    // 4: request held through a fill; no ack while busy
    push_miss(32'h0000_1000);
    push_miss(32'h0000_4000);
    start_miss(32'h0000_1000, 1'b1, a);
    miss_addr_i = 32'h0000_4000;
    bad = 0;
    n = 0;
    while (n < 100) begin
      #1;
      if (miss_ack_o && busy_o) bad++;
      if (fill_done_o) break;
      @(negedge clk); n++;
    end
    d = cyc;
    chk("t4_done_seen", fill_done_o, 1'b1);
    chk("t4_no_ack_busy", bad, 0);
    @(negedge clk); #1;
    chk("t4_ack_after_done", miss_ack_o, 1'b1);
    a = cyc;
    chk("t4_turnaround", a - d, 1);
    @(negedge clk);
    miss_req_i = 1'b0;
    #1;
    chk("t4_first_addr", mem_if.mem_addr_o, 32'h0000_4000);
    wait_done(d);
    chk("t4_latency", d - a, LW + 2);

    // 5: reset after two responses
    push_miss(32'h0000_1008);
    start_miss(32'h0000_1008, 1'b0, a);
    rv0 = rv_count;
    n = 0;
    while (rv_count < rv0 + 2 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("t5_two_rvalids", rv_count - rv0, 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check_all_zero("t5_reset");
    exp_addr_q.delete();
    crit_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (fill_done_o) bad++;
    end
    chk("t5_no_done", bad, 0);
    chk("t5_idle", busy_o, 1'b0);
    push_miss(32'h0000_1008);
    start_miss(32'h0000_1008, 1'b0, a);
    wait_done(d);
    chk("t5_latency", d - a, LW + 2);
    chk("t5_line", fill_line_o, line1);

    // 6: memory never grants
    gnt_never = 1'b1;
`ifdef YARP_LFU_TIMEOUT_EN
    begin
      done_t t;
      exp_addr_q.push_back(32'h0000_6000);
      t.addr = 32'h0000_6000;
      t.line = '0;
      t.err  = 1'b1;
      done_q.push_back(t);
    end
    start_miss(32'h0000_6000, 1'b0, a);
    wait_done(d);
    chk("t6_timeout_latency", d - a, 17);
    chk("t6_err", fill_err_o, 1'b1);
    @(negedge clk); #1;
    chk("t6_req_dropped", mem_if.mem_req_o, 1'b0);
    chk("t6_idle", busy_o, 1'b0);
`else
    push_miss(32'h0000_6000);
    start_miss(32'h0000_6000, 1'b0, a);
    n = 0;
    while (cyc < a + 1000 && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    chk("t6_still_busy", busy_o, 1'b1);
    chk("t6_still_req", mem_if.mem_req_o, 1'b1);
    chk("t6_no_err", fill_err_o, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/yarp_line_fill.md
Name: yarp_line_fill

Overview:
- Refill engine between the YARP cache miss path (instruction and data caches) and the backing main memory bus.
- Accepts one line-miss request and issues LINE_WORDS single-word reads in critical-word-first wrapping order.
- Collects the in-order responses into a line buffer and returns the critical word early plus the complete line.
- Sits directly downstream of the cache controller; the cache holds its busy/stall flag high until fill_done_o.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of 2, minimum 2.
- TIMEOUT_CYCLES, 256, cycles without any memory progress before the fill aborts; used only with YARP_LFU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- miss_req_i  in  1  cache requests a line fill; held until acked
- miss_addr_i  in  32  byte address of the missing word
- miss_ack_o  out  1  combinational: miss_req_i & state==IDLE; request captured on this edge
- busy_o  out  1  state != IDLE
- crit_valid_o  out  1  one-cycle pulse; critical word valid
- crit_data_o  out  32  critical word; holds until next crit_valid_o
- fill_done_o  out  1  one-cycle pulse; line complete
- fill_err_o  out  1  valid with fill_done_o; line aborted
- fill_addr_o  out  32  line-aligned address of the completed line
- fill_line_o  out  32*LINE_WORDS  line data, word 0 at LSBs; stable from fill_done_o until next fill_done_o
- mem_req_o  out  1  read request to memory
- mem_addr_o  out  32  word-aligned read address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; in order, at least 1 cycle after its grant
- mem_rdata_i  in  32  read data

Behaviour:
- Reset is asynchronous, active-low, on reset_n; the clock is clk.
- Reset: state IDLE; counters 0; all outputs 0, including fill_line_o, fill_addr_o and crit_data_o.
- A reset mid-fill aborts the fill immediately and raises no done pulse.
- FSM states IDLE, FILL, DONE.
- IDLE -> FILL on miss_ack_o.
  - Captures base = {miss_addr_i[31:2+IDXW], 0} and crit_idx = miss_addr_i[2+IDXW-1:2], where IDXW = log2(LINE_WORDS).
  - Byte offset [1:0] is ignored.
- FILL, issue side:
  - mem_req_o is high while issue_cnt < LINE_WORDS.
  - mem_addr_o = base + 4*((crit_idx + issue_cnt) mod LINE_WORDS).
  - issue_cnt increments on mem_gnt_i.
  - mem_req_o and mem_addr_o hold stable until granted.
  - The first mem_req_o is asserted the cycle after acceptance.
- FILL, response side:
  - Each mem_rvalid_i writes mem_rdata_i into word (crit_idx + rsp_cnt) mod LINE_WORDS, then rsp_cnt increments.
  - Issue and response run concurrently; up to LINE_WORDS reads may be outstanding.
- Early restart: crit_valid_o pulses the cycle after the rvalid with rsp_cnt==0; crit_data_o is registered from that data.
- FILL -> DONE on the rvalid with rsp_cnt==LINE_WORDS-1.
- DONE lasts one cycle: fill_done_o=1, and fill_line_o and fill_addr_o are updated. DONE -> IDLE.
- A new miss can be acked in the cycle after DONE (2-cycle minimum turnaround).
- miss_req_i while busy: miss_ack_o=0; the request is ignored until IDLE.
- mem_rvalid_i with rsp_cnt==issue_cnt, or while in IDLE/DONE: ignored. This is a protocol violation and is flagged by an assertion.
- Wrap-around:
  - Addresses never leave the line.
  - crit_idx = LINE_WORDS-1 yields order LINE_WORDS-1, 0, 1, ...
  - Address arithmetic is 32-bit; no carry beyond the line index field.
- Latency, gnt=1 every cycle, rvalid 1 cycle after gnt: fill_done_o at T+LINE_WORDS+2, where T is the ack cycle.

Optional Feature:
- YARP_LFU_TIMEOUT_EN defined:
  - A progress counter clears on ack, gnt or rvalid and increments in FILL otherwise.
  - On reaching TIMEOUT_CYCLES: mem_req_o drops, FILL -> DONE with fill_err_o=1.
  - fill_line_o holds the partial buffer; later stray rvalids are ignored.
- Undefined: no counter; fill_err_o tied 0; the FSM can wait indefinitely.

Decomposition:
- yarp_pkg additions: lfu_state_e enum (IDLE, FILL, DONE); LFU_LINE_WORDS default constant; word-index width function or constant.
- Sub-module yarp_lfu_line_buf: LINE_WORDS x 32 register array with rotated write index (crit_idx + rsp_cnt), a clear port, and a flat line output.

Test Plan:
1. Miss 0x0000_1008, LINE_WORDS=4, gnt always 1, rvalid 1 cycle later, rdata=addr.
   - mem_addr_o sequence 0x1008, 0x100C, 0x1000, 0x1004.
   - crit_data_o=0x1008; fill_addr_o=0x1000.
   - fill_line_o={0x100C, 0x1008, 0x1004, 0x1000}; fill_done_o 1 cycle after 4th rvalid, i.e. ack+6.
2. Aligned miss 0x2000 -> order 0x2000, 0x2004, 0x2008, 0x200C; crit word 0x2000.
3. Miss 0x300C, gnt low 3 cycles per beat:
   - mem_addr_o stays 0x300C for 4 cycles, then wraps to 0x3000.
   - Final line is identical to the no-backpressure case.
4. miss_req_i held high through a fill at 0x1000 with miss_addr_i=0x4000:
   - No second ack while busy_o=1.
   - Ack occurs the cycle after fill_done_o; next mem_addr_o=0x4000.
5. Reset asserted after 2 rvalids:
   - All outputs 0 asynchronously; no fill_done_o.
   - Post-reset miss 0x1008 completes normally.
6. YARP_LFU_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted:
   - fill_done_o=1 and fill_err_o=1 at ack+17.
   - mem_req_o=0 afterwards; without the macro, still busy at ack+1000.
